// File: rtl/alu_result_stage.sv
// Registered result stage behind the ALU: 2-entry skid buffer on a valid/ready
// handshake, plus the architectural {C,V,N,Z} status register fed back as carry.
`ifndef DEFAULT_WIDTH
`define DEFAULT_WIDTH 8
`endif

module alu_result_stage #(
   parameter int n = `DEFAULT_WIDTH,
   parameter int r = 3
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [n-1:0] in_result,
   input  logic         in_cout,
   input  logic         in_overflow,
   input  logic         in_sign,
   input  logic         in_zero,
   input  logic [3:0]   in_flag_we,
   input  logic [r-1:0] in_dest,
   input  logic         in_wb,
   input  logic         flag_load,
   input  logic [3:0]   flag_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [n-1:0] out_result,
   output logic [r-1:0] out_dest,
   output logic         out_wb,
   output logic [3:0]   flags,
   output logic         carry
);

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   state_t         state_q;
   logic           in_ready_q;
   logic           out_valid_q;
   logic [n-1:0]   main_result_q, skid_result_q;
   logic [r-1:0]   main_dest_q, skid_dest_q;
   logic           main_wb_q, skid_wb_q;
   logic [3:0]     flags_q, flags_d;
   logic           accept;

   assign accept = in_valid & in_ready_q;

   // Flags track accepted ops immediately so a back-to-back ALU op sees them.
   always_comb begin
      flags_d = flags_q;
      if (accept) begin
         if (in_flag_we[3]) flags_d[3] = in_cout;
         if (in_flag_we[2]) flags_d[2] = in_overflow;
         if (in_flag_we[1]) flags_d[1] = in_sign;
         if (in_flag_we[0]) flags_d[0] = in_zero;
      end
      if (flag_load) flags_d = flag_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= EMPTY;
         in_ready_q    <= 1'b1;
         out_valid_q   <= 1'b0;
         main_result_q <= '0;
         main_dest_q   <= '0;
         main_wb_q     <= 1'b0;
         skid_result_q <= '0;
         skid_dest_q   <= '0;
         skid_wb_q     <= 1'b0;
         flags_q       <= 4'b0000;
      end else begin
         flags_q <= flags_d;
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  main_result_q <= in_result;
                  main_dest_q   <= in_dest;
                  main_wb_q     <= in_wb;
                  out_valid_q   <= 1'b1;
                  state_q       <= ONE;
               end
            end
            ONE: begin
               if (accept && out_ready) begin
                  main_result_q <= in_result;
                  main_dest_q   <= in_dest;
                  main_wb_q     <= in_wb;
               end else if (accept) begin
                  skid_result_q <= in_result;
                  skid_dest_q   <= in_dest;
                  skid_wb_q     <= in_wb;
                  in_ready_q    <= 1'b0;
                  state_q       <= FULL;
               end else if (out_ready) begin
                  out_valid_q   <= 1'b0;
                  state_q       <= EMPTY;
               end
            end
            FULL: begin
               // in_ready_q is low here, so no accept can race the skid move.
               if (out_ready) begin
                  main_result_q <= skid_result_q;
                  main_dest_q   <= skid_dest_q;
                  main_wb_q     <= skid_wb_q;
                  in_ready_q    <= 1'b1;
                  state_q       <= ONE;
               end
            end
            default: begin
               state_q     <= EMPTY;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign out_result = main_result_q;
   assign out_dest   = main_dest_q;
   assign out_wb     = main_wb_q;
   assign flags      = flags_q;
   assign carry      = flags_q[3];

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage (n=8, r=3): entries queued on accept,
// compared on drain; status flags tracked by a small reference model.
module tb_alu_result_stage;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       in_valid, in_ready;
   logic [7:0] in_result;
   logic       in_cout, in_overflow, in_sign, in_zero;
   logic [3:0] in_flag_we;
   logic [2:0] in_dest;
   logic       in_wb;
   logic       flag_load;
   logic [3:0] flag_data;
   logic       out_valid, out_ready;
   logic [7:0] out_result;
   logic [2:0] out_dest;
   logic       out_wb;
   logic [3:0] flags;
   logic       carry;

   alu_result_stage #(.n(8), .r(3)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_result(in_result), .in_cout(in_cout), .in_overflow(in_overflow),
      .in_sign(in_sign), .in_zero(in_zero), .in_flag_we(in_flag_we),
      .in_dest(in_dest), .in_wb(in_wb),
      .flag_load(flag_load), .flag_data(flag_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_dest(out_dest), .out_wb(out_wb),
      .flags(flags), .carry(carry)
   );

   always #5 clk = ~clk;

   logic [31:0] sb[$];
   int          checks = 0;
   int          errors = 0;
   int          pop_cnt = 0;
   logic        acc_last;
   logic [3:0]  exp_flags;
   logic [7:0]  held;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      in_valid   = 1'b0;
      flag_load  = 1'b0;
      in_flag_we = 4'b0000;
   endtask

   task automatic drive(input logic [7:0] res, input logic [2:0] dst, input logic wb,
                        input logic [3:0] we, input logic c, input logic v,
                        input logic s, input logic z);
      in_valid    = 1'b1;
      in_result   = res;
      in_dest     = dst;
      in_wb       = wb;
      in_flag_we  = we;
      in_cout     = c;
      in_overflow = v;
      in_sign     = s;
      in_zero     = z;
   endtask

   // Called at a negedge: resolves this cycle's handshake, advances one clock.
   task automatic tick();
      logic [31:0] e;
      acc_last = in_valid && in_ready;
      if (out_valid && out_ready) begin
         pop_cnt++;
         if (sb.size() == 0) check("sb_underflow", 32'(1), 32'(0));
         else begin
            e = sb.pop_front();
            check("out_entry", 32'({out_wb, out_dest, out_result}), e);
         end
      end
      if (acc_last) begin
         sb.push_back(32'({in_wb, in_dest, in_result}));
         if (in_flag_we[3]) exp_flags[3] = in_cout;
         if (in_flag_we[2]) exp_flags[2] = in_overflow;
         if (in_flag_we[1]) exp_flags[1] = in_sign;
         if (in_flag_we[0]) exp_flags[0] = in_zero;
      end
      if (flag_load) exp_flags = flag_data;
      @(posedge clk);
      @(negedge clk);
      check("flags", 32'(flags), 32'(exp_flags));
      check("carry", 32'(carry), 32'(exp_flags[3]));
   endtask

   task automatic drain(input int max_cyc);
      int k;
      idle();
      out_ready = 1'b1;
      k = 0;
      while (sb.size() > 0 && k < max_cyc) begin
         tick();
         k++;
      end
      check("drain_done", 32'(sb.size()), 32'(0));
      check("drain_empty", 32'(out_valid), 32'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b1;
      idle();
      in_result = '0; in_dest = '0; in_wb = 1'b0;
      in_cout = 1'b0; in_overflow = 1'b0; in_sign = 1'b0; in_zero = 1'b0;
      flag_data = '0; out_ready = 1'b0;
      exp_flags = 4'b0000;
      #2 reset_n = 1'b0;
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'(0));
      check("rst_in_ready", 32'(in_ready), 32'(1));
      check("rst_flags", 32'(flags), 32'(0));
      check("rst_carry", 32'(carry), 32'(0));
      check("rst_out_data", 32'({out_wb, out_dest, out_result}), 32'(0));
      reset_n = 1'b1;
      @(negedge clk);

      // Single transfer
      out_ready = 1'b1;
      drive(8'hA5, 3'd2, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      idle();
      check("single_valid", 32'(out_valid), 32'(1));
      check("single_result", 32'(out_result), 32'h A5);
      check("single_dest", 32'(out_dest), 32'(2));
      check("single_flags", 32'(flags), 32'(4'b1000));
      check("single_carry", 32'(carry), 32'(1));
      tick();
      check("single_gone", 32'(out_valid), 32'(0));

      // Back-pressure: fill both entries, hold third beat at the producer
      out_ready = 1'b0;
      pop_cnt = 0;
      drive(8'h01, 3'd1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      check("bp_acc1", 32'(acc_last), 32'(1));
      drive(8'h02, 3'd2, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      check("bp_acc2", 32'(acc_last), 32'(1));
      check("bp_full_ready", 32'(in_ready), 32'(0));
      drive(8'h03, 3'd3, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      held = out_result;
      check("bp_head", 32'(held), 32'h01);
      for (int i = 0; i < 2; i++) begin
         tick();
         check("bp_no_acc", 32'(acc_last), 32'(0));
         check("bp_stable", 32'(out_result), 32'(held));
         check("bp_valid", 32'(out_valid), 32'(1));
      end
      out_ready = 1'b1;
      for (int i = 0; i < 10 && (sb.size() > 0 || in_valid); i++) begin
         tick();
         if (acc_last) idle();
      end
      check("bp_pop_count", 32'(pop_cnt), 32'(3));
      check("bp_empty", 32'(out_valid), 32'(0));

      // Masked flag update
      flag_load = 1'b1; flag_data = 4'b1111;
      tick();
      flag_load = 1'b0;
      drive(8'h44, 3'd1, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      idle();
      check("mask_flags", 32'(flags), 32'(4'b1101));
      drain(10);

      // Explicit load collides with an accept
      drive(8'h77, 3'd3, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b1);
      flag_load = 1'b1; flag_data = 4'b0100;
      tick();
      idle();
      check("coll_flags", 32'(flags), 32'(4'b0100));
      check("coll_enq", 32'(out_valid), 32'(1));
      drain(10);

      // Reset while FULL
      out_ready = 1'b0;
      drive(8'h11, 3'd1, 1'b1, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      drive(8'h22, 3'd2, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      idle();
      check("mid_full", 32'(in_ready), 32'(0));
      #2 reset_n = 1'b0;
      #1;
      check("mid_out_valid", 32'(out_valid), 32'(0));
      check("mid_in_ready", 32'(in_ready), 32'(1));
      check("mid_flags", 32'(flags), 32'(0));
      check("mid_carry", 32'(carry), 32'(0));
      sb.delete();
      exp_flags = 4'b0000;
      @(negedge clk);
      reset_n = 1'b1;
      out_ready = 1'b1;
      pop_cnt = 0;
      drive(8'h33, 3'd4, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      idle();
      tick();
      check("mid_pop_count", 32'(pop_cnt), 32'(1));
      check("mid_empty", 32'(out_valid), 32'(0));

      // Flags-only op
      out_ready = 1'b0;
      drive(8'h00, 3'd5, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      idle();
      check("fo_valid", 32'(out_valid), 32'(1));
      check("fo_wb", 32'(out_wb), 32'(0));
      check("fo_zero", 32'(flags[0]), 32'(1));
      drain(10);

      // Random traffic
      for (int i = 0; i < 300; i++) begin
         in_valid    = 1'($urandom_range(0, 1));
         in_result   = 8'($urandom_range(0, 255));
         in_dest     = 3'($urandom_range(0, 7));
         in_wb       = 1'($urandom_range(0, 1));
         in_flag_we  = 4'($urandom_range(0, 15));
         in_cout     = 1'($urandom_range(0, 1));
         in_overflow = 1'($urandom_range(0, 1));
         in_sign     = 1'($urandom_range(0, 1));
         in_zero     = 1'($urandom_range(0, 1));
         flag_load   = ($urandom_range(0, 7) == 0);
         flag_data   = 4'($urandom_range(0, 15));
         out_ready   = 1'($urandom_range(0, 1));
         tick();
      end
      drain(20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
Registered stage directly downstream of the ALU. It captures the ALU result and its flags (cout, overflow, sign, zero) behind a valid/ready handshake. It keeps the architectural status register (C, V, N, Z) and feeds C back to the ALU cin input for carry-chained ops. A 2-entry skid buffer keeps full throughput while the writeback consumer stalls.

Parameters:
n, `DEFAULT_WIDTH, datapath width; must match the ALU width
r, 3, destination register index width

Ports:
clk  input  1  clock; all state changes on rising edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  ALU result valid this cycle
in_ready  output  1  stage can accept; registered (no comb path from out_ready)
in_result  input  n  ALU out
in_cout  input  1  ALU cout
in_overflow  input  1  ALU overflow
in_sign  input  1  ALU sign
in_zero  input  1  ALU zero
in_flag_we  input  4  per-flag update mask {C,V,N,Z}
in_dest  input  r  destination register index
in_wb  input  1  result is written back (0 = flags-only op, e.g. compare)
flag_load  input  1  explicit status-register write
flag_data  input  4  {C,V,N,Z} value for flag_load
out_valid  output  1  entry available to writeback
out_ready  input  1  writeback accepts
out_result  output  n  registered result
out_dest  output  r  registered destination
out_wb  output  1  registered write-back enable
flags  output  4  status register {C,V,N,Z}
carry  output  1  flags[3]; drives ALU cin

Behaviour:
- Reset (async, reset_n=0):
  - out_valid=0, in_ready=1, flags=4'b0000, carry=0.
  - out_result, out_dest and out_wb = 0.
  - Both buffer entries invalid.
  - Reset mid-transfer discards both entries with no writeback.
- Accept event: in_valid & in_ready at a rising edge.
- Storage: main entry (drives out_*) and skid entry. Handshake state machine:
  - EMPTY: main invalid, skid invalid. Accept → main loaded → ONE.
  - ONE: main valid, skid invalid.
    - Accept and out_ready: main reloaded, stays ONE.
    - Accept, no out_ready: skid loaded → FULL.
    - out_ready, no accept: → EMPTY.
  - FULL: main valid, skid valid, in_ready=0.
    - out_ready: skid moves to main → ONE.
    - in_valid ignored.
- in_ready = (state != FULL), registered. No combinational path from out_ready to in_ready.
- Latency and throughput:
  - Latency in→out is 1 cycle.
  - Throughput is 1 per cycle while out_ready=1.
  - Order is strictly FIFO.
- out_* stay stable while out_valid=1 and out_ready=0.
- Flags update at accept time, not at drain, so the next ALU op sees current flags:
  - C←in_cout if in_flag_we[3]
  - V←in_overflow if in_flag_we[2]
  - N←in_sign if in_flag_we[1]
  - Z←in_zero if in_flag_we[0]
  - Unmasked bits hold.
- flag_load=1: flags←flag_data. It overrides any same-cycle accept update on all four bits. The data-path accept still proceeds.
- An entry with in_wb=0 still travels through the buffer; out_wb=0 marks it flags-only.
- carry is a direct copy of flags[3].
- No arithmetic is done here; widths pass through unmodified.

Test Plan (n=8, r=3):
- Reset, then single transfer: in_result=8'hA5, dest=2, wb=1, flag_we=4'b1111, cout=1, zero=0, out_ready=1 → next cycle:
  - out_valid=1, out_result=A5, out_dest=2, flags=4'b1000, carry=1.
  - The cycle after, out_valid=0.
- Back-pressure: out_ready=0, three consecutive in_valid beats 01,02,03 →
  - 01 and 02 accepted; in_ready=0 after the second accept; 03 held by the producer.
  - Raise out_ready → outputs 01,02,03 in order, no loss or duplicate, out_result stable while stalled.
- Masked flags: flags=4'b1111, accept with flag_we=4'b0010, sign=0 → flags=4'b1101. C, V, Z unchanged.
- Collision: accept with flag_we=4'b1111 (cout=1, zero=1) in the same cycle as flag_load=1, flag_data=4'b0100 → flags=4'b0100 and the result entry is still enqueued.
- Reset mid-operation: FULL state holding 11,22, assert reset_n=0 asynchronously between edges →
  - out_valid=0, in_ready=1, flags=0 immediately.
  - After release, the next accept delivers only the new value.
- Flags-only op: accept with wb=0, result=8'h00, zero=1, flag_we=4'b0001 → out_valid=1, out_wb=0, flags[0]=1.
